load_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the pipeline hazard detection unit. A per-register scoreboard

---
 rtl/load_hazard_scoreboard.sv | 157 +++++++++++++++
 tb/tb_load_hazard_scoreboard.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_scoreboard.sv
// load_hazard_scoreboard
//   ID-stage hazard unit with a per-register load scoreboard. Each register
//   has a small down-counter that is loaded with LOAD_LAT when a load to it
//   issues and counts down on every cycle the data memory is not busy. While
//   a source operand of the ID instruction has a nonzero count, the PC and
//   IF/ID are held and a bubble is pushed into ID/EX. Also sequences HLT
//   (drain outstanding loads, then halt), branch flush and memory freeze, and
//   keeps a saturating count of hazard-stall cycles.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   id_valid, id_opcode       ID instruction present / its opcode
//   id_rs, id_rt              ID source registers
//   id_uses_rs, id_uses_rt    source is actually read
//   id_is_load, id_rd         ID instruction is a load / its destination
//   ex_flush                  redirect resolved in EX; squash ID this cycle
//   mem_busy                  data memory stalled; freeze everything
//   pc_write, if_id_write     PC / IF/ID write enables
//   id_ex_bubble              select NOP into ID/EX
//   halted                    sticky halt flag (registered)
//   stall_cycles              saturating hazard-stall cycle count
module load_hazard_scoreboard #(
    parameter int         REG_W      = 4,
    parameter int         LOAD_LAT   = 1,
    parameter int         R0_ZERO    = 1,
    parameter logic [3:0] HLT_OPCODE = 4'hF,
    parameter int         SCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_load,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_flush,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              halted,
    output logic [SCNT_W-1:0] stall_cycles
);

    localparam int NUM_REGS = 2 ** REG_W;
    localparam int CNT_W    = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LOAD_LAT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT_DRAIN,
        ST_HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  busy_q [NUM_REGS];
    logic [CNT_W-1:0]  busy_d [NUM_REGS];
    logic [SCNT_W-1:0] stall_q, stall_d;
    logic              halted_q, halted_d;

    logic rs_zero, rt_zero, rd_zero;
    logic rs_hit, rt_hit, hazard, is_hlt, all_clear, issue;

    // Hazard detection and scoreboard-drain status.
    always_comb begin
        rs_zero   = (R0_ZERO != 0) && (id_rs == '0);
        rt_zero   = (R0_ZERO != 0) && (id_rt == '0);
        rd_zero   = (R0_ZERO != 0) && (id_rd == '0);
        rs_hit    = id_uses_rs && !rs_zero && (busy_q[id_rs] != '0);
        rt_hit    = id_uses_rt && !rt_zero && (busy_q[id_rt] != '0);
        hazard    = id_valid && (rs_hit || rt_hit);
        is_hlt    = id_valid && (id_opcode == HLT_OPCODE);
        all_clear = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (busy_q[r] != '0) all_clear = 1'b0;
        end
    end

    // Output priority and FSM next state: flush, then memory freeze, then
    // the halt states, then HLT entry, then the load-use hazard.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        state_d      = state_q;
        stall_d      = stall_q;
        issue        = 1'b0;
        if (ex_flush) begin
            id_ex_bubble = 1'b1;
            if (state_q == ST_HALT_DRAIN) state_d = ST_RUN;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (is_hlt) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = ST_HALT_DRAIN;
                    end else if (hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (stall_q != '1) stall_d = stall_q + 1'b1;
                    end else begin
                        issue = id_valid;
                    end
                end
                ST_HALT_DRAIN: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (all_clear) state_d = ST_HALTED;
                end
                default: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            endcase
        end
        halted_d = (state_d == ST_HALTED);
    end

    // Scoreboard: age every pending load unless frozen; a newly issued load
    // overrides the decrement of its own destination.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!mem_busy && (busy_q[r] != '0)) busy_d[r] = busy_q[r] - 1'b1;
            else                                busy_d[r] = busy_q[r];
        end
        if (issue && id_is_load && !rd_zero) busy_d[id_rd] = LAT_CNT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            stall_q  <= '0;
            halted_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) busy_q[r] <= '0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
            for (int r = 0; r < NUM_REGS; r++) busy_q[r] <= busy_d[r];
        end
    end

    assign halted       = halted_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard. Three instances share one input stream:
//   k=0: LOAD_LAT=1, R0_ZERO=1   k=1: LOAD_LAT=3, R0_ZERO=1   k=2: LOAD_LAT=2, R0_ZERO=0
// Every cycle each instance is compared to a reference model that tracks,
// per register, the "active" cycle at which a load result becomes usable.
module tb_load_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_uses_rs, id_uses_rt, id_is_load, ex_flush, mem_busy;
    logic [3:0] id_opcode, id_rs, id_rt, id_rd;

    logic [2:0]  pc_w, ii_w, bub_w, hlt_w;
    logic [15:0] sc0, sc1, sc2;

    load_hazard_scoreboard #(.REG_W(4), .LOAD_LAT(1), .R0_ZERO(1), .HLT_OPCODE(4'hF), .SCNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_load(id_is_load), .id_rd(id_rd),
        .ex_flush(ex_flush), .mem_busy(mem_busy), .pc_write(pc_w[0]), .if_id_write(ii_w[0]),
        .id_ex_bubble(bub_w[0]), .halted(hlt_w[0]), .stall_cycles(sc0));

    load_hazard_scoreboard #(.REG_W(4), .LOAD_LAT(3), .R0_ZERO(1), .HLT_OPCODE(4'hF), .SCNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_load(id_is_load), .id_rd(id_rd),
        .ex_flush(ex_flush), .mem_busy(mem_busy), .pc_write(pc_w[1]), .if_id_write(ii_w[1]),
        .id_ex_bubble(bub_w[1]), .halted(hlt_w[1]), .stall_cycles(sc1));

    load_hazard_scoreboard #(.REG_W(4), .LOAD_LAT(2), .R0_ZERO(0), .HLT_OPCODE(4'hF), .SCNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_load(id_is_load), .id_rd(id_rd),
        .ex_flush(ex_flush), .mem_busy(mem_busy), .pc_write(pc_w[2]), .if_id_write(ii_w[2]),
        .id_ex_bubble(bub_w[2]), .halted(hlt_w[2]), .stall_cycles(sc2));

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    function automatic logic [19:0] obs_of(input int k);
        case (k)
            0:       return {pc_w[0], ii_w[0], bub_w[0], hlt_w[0], sc0};
            1:       return {pc_w[1], ii_w[1], bub_w[1], hlt_w[1], sc1};
            default: return {pc_w[2], ii_w[2], bub_w[2], hlt_w[2], sc2};
        endcase
    endfunction

    // ---------------- reference model ----------------
    // act[k] counts cycles without mem_busy; a load issued at active cycle t
    // makes its register usable from active cycle t+1+LOAD_LAT onward.
    int lat [3] = '{1, 3, 2};
    int r0z [3] = '{1, 1, 0};
    int act [3];
    int ready_at [3][16];
    int mst [3];     // 0 running, 1 draining, 2 halted
    int mscnt [3];
    int cyc = 0;

    function automatic bit src_busy(input int k, input logic [3:0] r);
        return !(r0z[k] == 1 && r == 4'd0) && (act[k] < ready_at[k][r]);
    endfunction

    function automatic bit m_hazard(input int k);
        return id_valid && ((id_uses_rs && src_busy(k, id_rs)) || (id_uses_rt && src_busy(k, id_rt)));
    endfunction

    function automatic logic [19:0] m_expect(input int k);
        logic [2:0] o;
        bit is_h;
        is_h = id_valid && (id_opcode == 4'hF);
        if (ex_flush)         o = 3'b111;
        else if (mem_busy)    o = 3'b000;
        else if (mst[k] != 0) o = 3'b001;
        else if (is_h)        o = 3'b001;
        else if (m_hazard(k)) o = 3'b001;
        else                  o = 3'b110;
        return {o, (mst[k] == 2), 16'(mscnt[k])};
    endfunction

    function automatic void m_update(input int k);
        bit haz, is_h, clear, live;
        if (rst) begin
            act[k] = 0; mst[k] = 0; mscnt[k] = 0;
            for (int r = 0; r < 16; r++) ready_at[k][r] = 0;
            return;
        end
        haz   = m_hazard(k);
        is_h  = id_valid && (id_opcode == 4'hF);
        clear = 1'b1;
        for (int r = 0; r < 16; r++) if (ready_at[k][r] > act[k]) clear = 1'b0;
        live = !ex_flush && !mem_busy;
        if (live && mst[k] == 0 && !is_h && haz && mscnt[k] < 65535) mscnt[k]++;
        if (live && mst[k] == 0 && id_valid && !is_h && !haz && id_is_load &&
            !(r0z[k] == 1 && id_rd == 4'd0))
            ready_at[k][id_rd] = act[k] + 1 + lat[k];
        if (ex_flush && mst[k] == 1)                mst[k] = 0;
        else if (live && mst[k] == 0 && is_h)       mst[k] = 1;
        else if (live && mst[k] == 1 && clear)      mst[k] = 2;
        if (!mem_busy) act[k]++;
    endfunction

    // ---------------- stimulus records ----------------
    typedef struct {
        logic       rst, v;
        logic [3:0] op, rs, rt;
        logic       urs, urt, ld;
        logic [3:0] rd;
        logic       fl, mb;
        logic [19:0] exp;   // {pc_write, if_id_write, id_ex_bubble, halted, stall_cycles} of k=0
    } vec_t;

    // kind: 0 idle, 1 load Rr (base R1), 2 use Rr (ADD R9,Rr), 3 HLT
    function automatic vec_t mk(input int kind, input int r, input bit fl, input bit mb, input bit rs_,
                                input logic [2:0] o, input bit h, input int sc);
        vec_t v;
        v.rst = rs_;
        v.v   = (kind != 0);
        v.op  = (kind == 3) ? 4'hF : ((kind == 1) ? 4'h1 : 4'h2);
        v.rs  = (kind == 1) ? 4'd1 : 4'(r);
        v.rt  = 4'd5;
        v.urs = (kind == 1) || (kind == 2);
        v.urt = 1'b0;
        v.ld  = (kind == 1);
        v.rd  = (kind == 1) ? 4'(r) : 4'd9;
        v.fl  = fl;
        v.mb  = mb;
        v.exp = {o, h, 16'(sc)};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst = v.rst; id_valid = v.v; id_opcode = v.op; id_rs = v.rs; id_rt = v.rt;
        id_uses_rs = v.urs; id_uses_rt = v.urt; id_is_load = v.ld; id_rd = v.rd;
        ex_flush = v.fl; mem_busy = v.mb;
    endtask

    // Sample on the falling edge, checking every instance against the model.
    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("model k%0d cyc%0d", k, cyc), 32'(obs_of(k)), 32'(m_expect(k)));
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_update(k);
        cyc++;
        #1;
    endtask

    task automatic step(input vec_t v);
        apply(v); sample(); advance();
    endtask

    task automatic do_reset();
        step(mk(0, 0, 0, 0, 1, 3'b000, 0, 0));
    endtask

    vec_t tbl[$];

    initial begin
        // Table for instance k=0 (LOAD_LAT=1, R0_ZERO=1).
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b110, 0, 0));   // reset state
        tbl.push_back(mk(1, 3, 0, 0, 0, 3'b110, 0, 0));   // load R3
        tbl.push_back(mk(2, 3, 0, 0, 0, 3'b001, 0, 0));   // use R3: one stall
        tbl.push_back(mk(2, 3, 0, 0, 0, 3'b110, 0, 1));   // proceeds
        tbl.push_back(mk(1, 3, 0, 0, 0, 3'b110, 0, 1));
        tbl.push_back(mk(2, 3, 1, 0, 0, 3'b111, 0, 1));   // hazard + flush
        tbl.push_back(mk(2, 3, 0, 0, 0, 3'b110, 0, 1));
        tbl.push_back(mk(3, 0, 1, 0, 0, 3'b111, 0, 1));   // HLT squashed
        tbl.push_back(mk(2, 4, 0, 0, 0, 3'b110, 0, 1));
        tbl.push_back(mk(3, 0, 0, 0, 0, 3'b001, 0, 1));   // HLT -> drain
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b111, 0, 1));   // flush -> run
        tbl.push_back(mk(2, 4, 0, 0, 0, 3'b110, 0, 1));
        tbl.push_back(mk(1, 3, 0, 0, 0, 3'b110, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(2, 3, 0, 1, 0, 3'b000, 0, 1)); // frozen
        tbl.push_back(mk(2, 3, 0, 0, 0, 3'b001, 0, 1));   // stall resumes
        tbl.push_back(mk(2, 3, 0, 0, 0, 3'b110, 0, 2));
        tbl.push_back(mk(1, 3, 0, 0, 0, 3'b110, 0, 2));
        tbl.push_back(mk(2, 3, 0, 0, 1, 3'b001, 0, 2));   // rst during stall
        tbl.push_back(mk(2, 3, 0, 0, 0, 3'b110, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b110, 0, 0));   // load R0
        tbl.push_back(mk(2, 0, 0, 0, 0, 3'b110, 0, 0));   // use R0: no stall
        tbl.push_back(mk(3, 0, 0, 0, 0, 3'b001, 0, 0));   // HLT
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b001, 0, 0));   // drained
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b001, 1, 0));   // halted
        tbl.push_back(mk(2, 4, 0, 0, 0, 3'b001, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b001, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b110, 0, 0));

        // clock/reset
        apply(mk(0, 0, 0, 0, 1, 3'b000, 0, 0));
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) m_update(k);
        #1;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            sample();
            check($sformatf("tbl[%0d]", i), 32'(obs_of(0)), 32'(tbl[i].exp));
            advance();
        end

        // LOAD_LAT=3 (k=1): three stalls on R2, none on R7.
        do_reset();
        apply(mk(1, 2, 0, 0, 0, 0, 0, 0)); sample(); check("t2 load pc", 32'(pc_w[1]), 1); advance();
        for (int i = 0; i < 3; i++) begin
            apply(mk(2, 2, 0, 0, 0, 0, 0, 0)); sample();
            check($sformatf("t2 stall%0d", i), 32'({pc_w[1], ii_w[1], bub_w[1]}), 32'b001); advance();
        end
        apply(mk(2, 2, 0, 0, 0, 0, 0, 0)); sample();
        check("t2 go", 32'({pc_w[1], ii_w[1], bub_w[1]}), 32'b110);
        check("t2 count", 32'(sc1), 3); advance();
        step(mk(1, 2, 0, 0, 0, 0, 0, 0));
        apply(mk(2, 7, 0, 0, 0, 0, 0, 0)); sample();
        check("t2 r7", 32'({pc_w[1], ii_w[1], bub_w[1]}), 32'b110); advance();

        // Reset during a long stall clears pending loads.
        do_reset();
        step(mk(1, 2, 0, 0, 0, 0, 0, 0));
        step(mk(2, 2, 0, 0, 0, 0, 0, 0));
        step(mk(2, 2, 0, 0, 1, 0, 0, 0));
        apply(mk(2, 2, 0, 0, 0, 0, 0, 0)); sample();
        check("t6 rst out", 32'({pc_w[1], ii_w[1], bub_w[1]}), 32'b110); advance();

        // R0 handling: k=1 ignores R0, k=2 (LOAD_LAT=2) tracks it.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(2, 0, 0, 0, 0, 0, 0, 0)); sample();
        check("t3 r0 zero", 32'(pc_w[1]), 1);
        check("t3 r0 c0", 32'(pc_w[2]), 0); advance();
        apply(mk(2, 0, 0, 0, 0, 0, 0, 0)); sample(); check("t3 r0 c1", 32'(pc_w[2]), 0); advance();
        apply(mk(2, 0, 0, 0, 0, 0, 0, 0)); sample();
        check("t3 r0 c2", 32'(pc_w[2]), 1);
        check("t3 r0 count", 32'(sc2), 2); advance();

        // HLT behind a LOAD_LAT=2 load (k=2).
        do_reset();
        step(mk(1, 6, 0, 0, 0, 0, 0, 0));
        apply(mk(3, 0, 0, 0, 0, 0, 0, 0)); sample();
        check("t4 hlt out", 32'({pc_w[2], ii_w[2], bub_w[2], hlt_w[2]}), 32'b0010); advance();
        for (int i = 0; i < 2; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0)); sample();
            check($sformatf("t4 drain%0d", i), 32'({bub_w[2], hlt_w[2]}), 32'b10); advance();
        end
        for (int i = 0; i < 4; i++) begin
            apply(mk(2, 4, 0, 0, 0, 0, 0, 0)); sample();
            check($sformatf("t4 halted%0d", i), 32'({pc_w[2], hlt_w[2]}), 32'b01); advance();
        end
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0)); sample(); check("t4 rst", 32'(hlt_w[2]), 0); advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            vec_t v;
            v.rst = ($urandom_range(0, 99) == 0);
            v.v   = ($urandom_range(0, 4) != 0);
            v.op  = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            v.rs  = 4'($urandom_range(0, 7));
            v.rt  = 4'($urandom_range(0, 7));
            v.urs = $urandom_range(0, 1);
            v.urt = $urandom_range(0, 1);
            v.ld  = ($urandom_range(0, 2) == 0);
            v.rd  = 4'($urandom_range(0, 7));
            v.fl  = ($urandom_range(0, 9) == 0);
            v.mb  = ($urandom_range(0, 5) == 0);
            v.exp = '0;
            step(v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
